// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared state encoding and constants for the SPI frame receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    END   = 2'd2
  } spi_state_t;

  localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : W-bit multi-flop synchroniser for asynchronous pin inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync
  import spi_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [SYNC_STAGES-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_pipe[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frame_rx
//  Description : Oversampled SPI slave frame receiver with exact bit counting,
//                short/long frame detection and a status word returned on sdo.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int                 FRAME_W   = 128,
  parameter int                 CPOL      = 0,
  parameter int                 CPHA      = 0,
  parameter logic [FRAME_W-1:0] MATCH_PAT = FRAME_W'(128'hFF00FF00FF00FF00FF00FF00FF00FF00)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               load,
  output logic               sdo,
  input  logic [FRAME_W-1:0] tx_word,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               match,
  output logic               busy
);

  localparam int CNT_W = $clog2(FRAME_W + 2);

  logic [2:0]         w_sync;
  logic               w_sck_s, w_sdi_s, w_load_s;
  logic               w_rise, w_fall, w_sample, w_shift;
  logic               w_load_rise, w_load_fall;
  spi_state_t         r_state, w_next;
  logic               r_sck_prev, r_load_prev;
  logic [FRAME_W-1:0] r_shreg, r_tx, r_frame_data;
  logic [CNT_W-1:0]   r_cnt, r_txcnt;
  logic               r_sdo, r_frame_valid, r_frame_err, r_match;

  spi_sync #(.W(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   ({sck, sdi, load}),
    .o_q   (w_sync)
  );

  assign {w_sck_s, w_sdi_s, w_load_s} = w_sync;

  assign w_rise      = w_sck_s & ~r_sck_prev;
  assign w_fall      = ~w_sck_s & r_sck_prev;
  // Leading edge is a rise when CPOL=0; CPHA picks leading or trailing for sampling.
  assign w_sample    = (CPOL == CPHA) ? w_rise : w_fall;
  assign w_shift     = (CPOL == CPHA) ? w_fall : w_rise;
  assign w_load_rise = w_load_s & ~r_load_prev;
  assign w_load_fall = ~w_load_s & r_load_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_load_rise) w_next = SHIFT;
      SHIFT:   if (w_load_fall) w_next = END;
      END:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_prev    <= 1'b0;
      r_load_prev   <= 1'b0;
      r_shreg       <= '0;
      r_tx          <= '0;
      r_cnt         <= '0;
      r_txcnt       <= '0;
      r_sdo         <= 1'b0;
      r_frame_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_match       <= 1'b0;
    end else begin
      r_sck_prev    <= w_sck_s;
      r_load_prev   <= w_load_s;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_rise) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            if (CPHA == 0) begin
              r_sdo   <= tx_word[FRAME_W-1];
              r_tx    <= tx_word << 1;
              r_txcnt <= CNT_W'(1);
            end else begin
              r_sdo   <= 1'b0;
              r_tx    <= tx_word;
              r_txcnt <= '0;
            end
          end
        end
        SHIFT: begin
          // Bits past FRAME_W are dropped; the count keeps going to flag the overrun.
          if (w_sample) begin
            if (r_cnt < CNT_W'(FRAME_W)) r_shreg <= {r_shreg[FRAME_W-2:0], w_sdi_s};
            if (r_cnt <= CNT_W'(FRAME_W)) r_cnt <= r_cnt + 1'b1;
          end
          if (w_shift) begin
            if (r_txcnt < CNT_W'(FRAME_W)) begin
              r_sdo   <= r_tx[FRAME_W-1];
              r_tx    <= r_tx << 1;
              r_txcnt <= r_txcnt + 1'b1;
            end else begin
              r_sdo <= 1'b0;
            end
          end
        end
        END: begin
          r_sdo <= 1'b0;
          if (r_cnt == CNT_W'(FRAME_W)) begin
            r_frame_data  <= r_shreg;
            r_match       <= (r_shreg == MATCH_PAT);
            r_frame_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: r_sdo <= 1'b0;
      endcase
    end
  end

  assign sdo         = r_sdo;
  assign frame_data  = r_frame_data;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign match       = r_match;
  assign busy        = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_frame_rx
//  Description : Scoreboard bench for spi_frame_rx in all four SPI modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_rx;

  localparam int           H   = 6;
  localparam logic [127:0] PAT = 128'hFF00FF00FF00FF00FF00FF00FF00FF00;

  typedef struct {
    int           inst;
    bit           err;
    logic [127:0] data;
    bit           mt;
  } exp_t;

  exp_t         sbq[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sck[4], sdi[4], load[4], sdo[4], fv[4], fe[4], mt[4], by[4];
  logic [127:0] tx0, fd0;
  logic [31:0]  tx32[1:3], fd32[1:3];
  logic [127:0] last_d[4];
  bit           last_m[4];
  logic [255:0] miso;

  always #5 clk = ~clk;

  spi_frame_rx #(.FRAME_W(128), .CPOL(0), .CPHA(0), .MATCH_PAT(PAT)) u_m0 (
    .clk(clk), .reset(reset), .sck(sck[0]), .sdi(sdi[0]), .load(load[0]), .sdo(sdo[0]),
    .tx_word(tx0), .frame_data(fd0), .frame_valid(fv[0]), .frame_err(fe[0]),
    .match(mt[0]), .busy(by[0])
  );

  generate
    for (genvar g = 1; g < 4; g++) begin : g_mode
      spi_frame_rx #(
        .FRAME_W(32), .CPOL(g / 2), .CPHA(g % 2),
        .MATCH_PAT((g == 2) ? 32'h0 : 32'hDEADBEEF)
      ) u_dut (
        .clk(clk), .reset(reset), .sck(sck[g]), .sdi(sdi[g]), .load(load[g]), .sdo(sdo[g]),
        .tx_word(tx32[g]), .frame_data(fd32[g]), .frame_valid(fv[g]), .frame_err(fe[g]),
        .match(mt[g]), .busy(by[g])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_ok(input int k, input logic [127:0] d, input bit m);
    sbq.push_back('{k, 1'b0, d, m});
    last_d[k] = d;
    last_m[k] = m;
  endtask

  task automatic push_err(input int k);
    sbq.push_back('{k, 1'b1, last_d[k], last_m[k]});
  endtask

  // Master model: bit i of the frame is data[nbits-1-i]; sdo is captured at the master's sample edge.
  task automatic xfer(input int m, input int nbits, input logic [255:0] data, input int gap,
                      input bit abort, output logic [255:0] rx);
    bit cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rx = '0;
    @(negedge clk);
    load[m] = 1'b1;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        sdi[m] = data[nbits-1-i];
        repeat (H) @(negedge clk);
        rx[nbits-1-i] = sdo[m];
        sck[m] = ~cpol;
        repeat (H) @(negedge clk);
        sck[m] = cpol;
      end else begin
        sck[m] = ~cpol;
        sdi[m] = data[nbits-1-i];
        repeat (H) @(negedge clk);
        rx[nbits-1-i] = sdo[m];
        sck[m] = cpol;
        repeat (H) @(negedge clk);
      end
      if (i == 0) chk($sformatf("busy_inst%0d", m), {127'b0, by[m]}, 128'd1);
    end
    if (abort) return;
    repeat (H) @(negedge clk);
    load[m] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t         e;
    logic [127:0] d;
    for (int k = 0; k < 4; k++) begin
      if (fv[k] === 1'b1 || fe[k] === 1'b1) begin
        case (k)
          1:       d = {96'b0, fd32[1]};
          2:       d = {96'b0, fd32[2]};
          3:       d = {96'b0, fd32[3]};
          default: d = fd0;
        endcase
        if (fv[k] === 1'b1 && fe[k] === 1'b1)
          chk($sformatf("valid_err_overlap_inst%0d", k), 128'd1, 128'd0);
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pulse inst%0d: got valid=%0b err=%0b expected no pulse",
                   k, fv[k], fe[k]);
        end else begin
          e = sbq.pop_front();
          chk("pulse_inst", 128'(k), 128'(e.inst));
          chk($sformatf("kind_err_inst%0d", k), {127'b0, fe[k]}, {127'b0, e.err});
          chk($sformatf("data_inst%0d", k), d, e.data);
          chk($sformatf("match_inst%0d", k), {127'b0, mt[k]}, {127'b0, e.mt});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      sck[k]    = (k >= 2);
      sdi[k]    = 1'b0;
      load[k]   = 1'b0;
      last_d[k] = '0;
      last_m[k] = 1'b0;
    end
    tx0 = '0;
    for (int k = 1; k < 4; k++) tx32[k] = '0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_frame_data", fd0, 128'd0);
    chk("rst_valid_err", {126'b0, fv[0], fe[0]}, 128'd0);
    chk("rst_match_busy", {126'b0, mt[0], by[0]}, 128'd0);
    chk("rst_sdo", {127'b0, sdo[0]}, 128'd0);
    chk("rst_frame_data32", {96'b0, fd32[2]}, 128'd0);

    // Matching pattern in mode 0
    push_ok(0, PAT, 1'b1);
    xfer(0, 128, {128'b0, PAT}, 8, 1'b0, miso);

    // Non-matching word plus status word returned on sdo
    tx0 = {16{8'hA5}};
    push_ok(0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0);
    xfer(0, 128, {128'b0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677}, 8, 1'b0, miso);
    chk("sdo_mode0", miso[127:0], {16{8'hA5}});

    // Short then long frame: errors, previous frame retained
    push_err(0);
    xfer(0, 127, {129'b0, 127'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA}, 8, 1'b0, miso);
    push_err(0);
    xfer(0, 130, {126'b0, 130'h3_FFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000}, 8, 1'b0, miso);

    // Modes 1..3 at 32 bits
    for (int m = 1; m < 4; m++) begin
      tx32[m] = 32'h5A3C_0F00 | 32'(m);
      push_ok(m, {96'b0, 32'hDEADBEEF}, (m != 2));
      xfer(m, 32, {224'b0, 32'hDEADBEEF}, 8, 1'b0, miso);
      chk($sformatf("sdo_mode%0d", m), {96'b0, miso[31:0]}, {96'b0, 32'h5A3C_0F00 | 32'(m)});
    end

    // Reset in the middle of a frame discards it
    xfer(0, 60, {196'b0, 60'hFED_CBA9_8765_4321}, 0, 1'b1, miso);
    @(negedge clk);
    reset   = 1'b1;
    load[0] = 1'b0;
    sck[0]  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      last_d[k] = '0;
      last_m[k] = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("midreset_frame_data", fd0, 128'd0);
    chk("midreset_frame_data32", {96'b0, fd32[1]}, 128'd0);
    push_ok(0, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_9BDF, 1'b0);
    xfer(0, 128, {128'b0, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_9BDF}, 8, 1'b0, miso);

    // Back-to-back frames with minimum gap, then an empty load pulse
    push_ok(0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    xfer(0, 128, {128'b0, 128'h1111_2222_3333_4444_5555_6666_7777_8888}, 3, 1'b0, miso);
    push_ok(0, PAT, 1'b1);
    xfer(0, 128, {128'b0, PAT}, 8, 1'b0, miso);
    push_err(0);
    xfer(0, 0, 256'b0, 8, 1'b0, miso);

    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 128'(sbq.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
